i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with glitch-filtered SCL/SDA, 7-bit masked address
// match, clock stretching, and AXI-stream style byte ports. Bytes written by
// the I2C master leave on m_axis_data; bytes read by the master come in on
// s_axis_data. Lines are open-drain: a pin pulls low only when its _t is 0.
//
// Handshake rule for both byte streams: a byte moves on a rising clk edge
// where tvalid and tready are both high; the source holds tdata stable and
// keeps tvalid high until that edge, and tvalid never depends on tready.
module i2c_slave #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       release_bus,
  input  logic [7:0] s_axis_data_tdata,
  input  logic       s_axis_data_tvalid,
  output logic       s_axis_data_tready,
  output logic [7:0] m_axis_data_tdata,
  output logic       m_axis_data_tvalid,
  input  logic       m_axis_data_tready,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       busy,
  output logic [6:0] bus_address,
  output logic       bus_addressed,
  output logic       bus_active,
  input  logic       enable,
  input  logic [6:0] device_address,
  input  logic [6:0] device_address_mask
);

  typedef enum logic [2:0] {
    IDLE,
    ADDRESS,
    ACK,
    WRITE_1,
    WRITE_2,
    READ_1,
    READ_2,
    READ_3
  } state_t;

  // Input conditioning
  logic                  r_scl_sync;
  logic                  r_sda_sync;
  logic [FILTER_LEN-1:0] r_scl_hist;
  logic [FILTER_LEN-1:0] r_sda_hist;
  logic                  r_scl_filt;
  logic                  r_sda_filt;
  logic                  r_scl_prev;
  logic                  r_sda_prev;

  // Bus events derived from the filtered levels
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_addr_match;
  logic w_m_free;

  // Protocol state and registered outputs
  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_bit_cnt;
  logic [3:0] w_bit_cnt_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic       r_rw;
  logic       w_rw_next;
  logic       r_sda_t;
  logic       w_sda_t_next;
  logic       r_scl_t;
  logic       w_scl_t_next;
  logic [6:0] r_addr;
  logic [6:0] w_addr_next;
  logic       r_addressed;
  logic       w_addressed_next;
  logic       r_active;
  logic       w_active_next;
  logic [7:0] r_m_tdata;
  logic [7:0] w_m_tdata_next;
  logic       r_m_tvalid;
  logic       w_m_tvalid_next;
  logic       r_s_tready;
  logic       w_s_tready_next;

  // Synchronise the pins, keep the last FILTER_LEN samples, and move the
  // filtered level only when every stored sample agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 1'b1;
      r_sda_sync <= 1'b1;
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= scl_i;
      r_sda_sync <= sda_i;
      r_scl_hist <= (r_scl_hist << 1) | FILTER_LEN'(r_scl_sync);
      r_sda_hist <= (r_sda_hist << 1) | FILTER_LEN'(r_sda_sync);
      if (&r_scl_hist) begin
        r_scl_filt <= 1'b1;
      end else if (~|r_scl_hist) begin
        r_scl_filt <= 1'b0;
      end
      if (&r_sda_hist) begin
        r_sda_filt <= 1'b1;
      end else if (~|r_sda_hist) begin
        r_sda_filt <= 1'b0;
      end
      r_scl_prev <= r_scl_filt;
      r_sda_prev <= r_sda_filt;
    end
  end

  assign w_scl_rise = r_scl_filt & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_filt & r_scl_prev;
  // START/STOP need SCL high on both the previous and current filtered sample
  assign w_start    = r_scl_filt & r_scl_prev & r_sda_prev & ~r_sda_filt;
  assign w_stop     = r_scl_filt & r_scl_prev & ~r_sda_prev & r_sda_filt;

  // Shift register holds {addr[6:0], rw} once eight address bits are in
  assign w_addr_match = enable &&
    ((r_shift[7:1] & device_address_mask) == (device_address & device_address_mask));

  // Output register can take a new byte when empty or emptying this cycle
  assign w_m_free = ~r_m_tvalid | m_axis_data_tready;

  // Register the protocol state and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_sda_t     <= 1'b1;
      r_scl_t     <= 1'b1;
      r_addr      <= '0;
      r_addressed <= 1'b0;
      r_active    <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_s_tready  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_rw        <= w_rw_next;
      r_sda_t     <= w_sda_t_next;
      r_scl_t     <= w_scl_t_next;
      r_addr      <= w_addr_next;
      r_addressed <= w_addressed_next;
      r_active    <= w_active_next;
      r_m_tdata   <= w_m_tdata_next;
      r_m_tvalid  <= w_m_tvalid_next;
      r_s_tready  <= w_s_tready_next;
    end
  end

  // Next-state and output decode. release_bus outranks STOP, STOP outranks
  // START, and both bus conditions outrank the per-state byte handling.
  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_rw_next        = r_rw;
    w_sda_t_next     = r_sda_t;
    w_scl_t_next     = r_scl_t;
    w_addr_next      = r_addr;
    w_addressed_next = r_addressed;
    w_active_next    = r_active;
    w_m_tdata_next   = r_m_tdata;
    w_m_tvalid_next  = r_m_tvalid & ~m_axis_data_tready;
    w_s_tready_next  = 1'b0;

    // bus_active follows the wire, whatever the FSM is doing
    if (w_stop) begin
      w_active_next = 1'b0;
    end else if (w_start) begin
      w_active_next = 1'b1;
    end

    if (release_bus) begin
      w_state_next = IDLE;
      w_sda_t_next = 1'b1;
      w_scl_t_next = 1'b1;
    end else if (w_stop) begin
      w_state_next     = IDLE;
      w_sda_t_next     = 1'b1;
      w_scl_t_next     = 1'b1;
      w_addressed_next = 1'b0;
    end else if (w_start) begin
      w_state_next     = ADDRESS;
      w_bit_cnt_next   = '0;
      w_addressed_next = 1'b0;
      w_sda_t_next     = 1'b1;
      w_scl_t_next     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_sda_t_next = 1'b1;
          w_scl_t_next = 1'b1;
        end
        ADDRESS: begin
          if (w_scl_rise) begin
            w_shift_next   = {r_shift[6:0], r_sda_filt};
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end else if (r_bit_cnt == 4'd8 && !r_scl_filt) begin
            // SCL has fallen after the R/W bit: ACK now or drop out
            w_addr_next = r_shift[7:1];
            w_rw_next   = r_shift[0];
            if (w_addr_match) begin
              w_state_next     = ACK;
              w_sda_t_next     = 1'b0;
              w_addressed_next = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
        ACK: begin
          // Falling edge ends the ACK clock; let go of SDA straight away
          if (w_scl_fall) begin
            w_sda_t_next   = 1'b1;
            w_bit_cnt_next = '0;
            w_state_next   = r_rw ? READ_1 : WRITE_1;
          end
        end
        WRITE_1: begin
          if (w_scl_rise) begin
            w_shift_next   = {r_shift[6:0], r_sda_filt};
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end else if (r_bit_cnt == 4'd8 && !r_scl_filt) begin
            if (!enable) begin
              w_state_next = IDLE;
              w_scl_t_next = 1'b1;
            end else if (!w_m_free) begin
              // Previous byte still unread: hold SCL low until it drains
              w_scl_t_next = 1'b0;
            end else begin
              w_m_tdata_next  = r_shift;
              w_m_tvalid_next = 1'b1;
              w_sda_t_next    = 1'b0;
              w_scl_t_next    = 1'b1;
              w_state_next    = WRITE_2;
            end
          end
        end
        WRITE_2: begin
          if (w_scl_fall) begin
            w_sda_t_next   = 1'b1;
            w_bit_cnt_next = '0;
            w_state_next   = WRITE_1;
          end
        end
        READ_1: begin
          // Only act with SCL low so SDA never moves during a high phase
          if (!r_scl_filt) begin
            if (s_axis_data_tvalid) begin
              w_shift_next    = s_axis_data_tdata;
              w_s_tready_next = 1'b1;
              w_sda_t_next    = s_axis_data_tdata[7];
              w_scl_t_next    = 1'b1;
              w_bit_cnt_next  = '0;
              w_state_next    = READ_2;
            end else begin
              w_scl_t_next = 1'b0;
            end
          end
        end
        READ_2: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd7) begin
              w_sda_t_next = 1'b1;
              w_state_next = READ_3;
            end else begin
              w_shift_next   = {r_shift[6:0], 1'b0};
              w_sda_t_next   = r_shift[6];
              w_bit_cnt_next = r_bit_cnt + 4'd1;
            end
          end
        end
        READ_3: begin
          // Master ACK (low) asks for another byte; NACK ends the read
          if (w_scl_rise) begin
            w_state_next = r_sda_filt ? IDLE : READ_1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_sda_t_next = 1'b1;
          w_scl_t_next = 1'b1;
        end
      endcase
    end
  end

  assign scl_o              = r_scl_t;
  assign scl_t              = r_scl_t;
  assign sda_o              = r_sda_t;
  assign sda_t              = r_sda_t;
  assign busy               = (r_state != IDLE);
  assign bus_address        = r_addr;
  assign bus_addressed      = r_addressed;
  assign bus_active         = r_active;
  assign m_axis_data_tdata  = r_m_tdata;
  assign m_axis_data_tvalid = r_m_tvalid;
  assign s_axis_data_tready = r_s_tready;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bit-banged I2C master against i2c_slave with
// device_address 0x50, mask 0x7F, FILTER_LEN 4, SCL half-period 20 clk.
module tb_i2c_slave;

  localparam int HALF = 20;

  logic       clk;
  logic       rst;
  logic       release_bus;
  logic [7:0] s_axis_data_tdata;
  logic       s_axis_data_tvalid;
  logic       s_axis_data_tready;
  logic [7:0] m_axis_data_tdata;
  logic       m_axis_data_tvalid;
  logic       m_axis_data_tready;
  logic       scl_i, scl_o, scl_t;
  logic       sda_i, sda_o, sda_t;
  logic       busy;
  logic [6:0] bus_address;
  logic       bus_addressed;
  logic       bus_active;
  logic       enable;
  logic [6:0] device_address;
  logic [6:0] device_address_mask;

  logic m_scl;
  logic m_sda;
  logic src_en;
  logic w_scl_line;
  logic w_sda_line;

  int n_checks = 0;
  int n_errors = 0;

  // wired-AND bus: master and slave can each only pull low
  assign w_scl_line = m_scl & (scl_t | scl_o);
  assign w_sda_line = m_sda & (sda_t | sda_o);
  assign scl_i      = w_scl_line;
  assign sda_i      = w_sda_line;

  i2c_slave #(.FILTER_LEN(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .release_bus         (release_bus),
    .s_axis_data_tdata   (s_axis_data_tdata),
    .s_axis_data_tvalid  (s_axis_data_tvalid),
    .s_axis_data_tready  (s_axis_data_tready),
    .m_axis_data_tdata   (m_axis_data_tdata),
    .m_axis_data_tvalid  (m_axis_data_tvalid),
    .m_axis_data_tready  (m_axis_data_tready),
    .scl_i               (scl_i),
    .scl_o               (scl_o),
    .scl_t               (scl_t),
    .sda_i               (sda_i),
    .sda_o               (sda_o),
    .sda_t               (sda_t),
    .busy                (busy),
    .bus_address         (bus_address),
    .bus_addressed       (bus_addressed),
    .bus_active          (bus_active),
    .enable              (enable),
    .device_address      (device_address),
    .device_address_mask (device_address_mask)
  );

  // clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // byte source for reads: alternates 0xC3, 0x5A, advancing on each handshake
  logic src_idx = 1'b0;
  assign s_axis_data_tvalid = src_en;
  assign s_axis_data_tdata  = src_idx ? 8'h5A : 8'hC3;

  // monitors: SDA pull-low cycles, tready pulses, bytes leaving m_axis
  int         sda_low_cnt = 0;
  int         tready_cnt  = 0;
  int         got_cnt     = 0;
  logic [7:0] got_data [0:15];

  always @(posedge clk) begin
    if (!sda_t) sda_low_cnt <= sda_low_cnt + 1;
    if (s_axis_data_tready) tready_cnt <= tready_cnt + 1;
    if (s_axis_data_tvalid && s_axis_data_tready) src_idx <= ~src_idx;
    if (m_axis_data_tvalid && m_axis_data_tready) begin
      got_data[got_cnt[3:0]] <= m_axis_data_tdata;
      got_cnt <= got_cnt + 1;
    end
  end

  // scoreboard for m_axis bytes
  logic [7:0] exp_q[$];
  int         got_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drain_expected();
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_cnt) chk("m_axis_byte", 32'(got_data[got_rd[3:0]]), 32'(e));
      else chk("m_axis_missing", 32'(got_cnt), 32'(got_rd + 1));
      got_rd++;
    end
    chk("m_axis_count", 32'(got_cnt), 32'(got_rd));
  endtask

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    @(negedge clk);
    while (w_scl_line !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (w_scl_line !== 1'b1) chk("scl_release_timeout", 32'(w_scl_line), 32'd1);
  endtask

  task automatic clock_bit(input logic drv, output logic smp);
    wait_clks(HALF / 2);
    m_sda = drv;
    wait_clks(HALF / 2);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(HALF / 2);
    smp = w_sda_line;
    wait_clks(HALF / 2);
    m_scl = 1'b0;
  endtask

  task automatic send_bits8(input logic [7:0] b);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits8(b);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
    clock_bit(mack, dummy);
  endtask

  task automatic i2c_start();
    wait_clks(HALF / 2);
    m_sda = 1'b1;
    wait_clks(HALF / 2);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(HALF);
    m_sda = 1'b0;
    wait_clks(HALF);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(HALF / 2);
    m_sda = 1'b0;
    wait_clks(HALF / 2);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(HALF);
    m_sda = 1'b1;
    wait_clks(HALF);
  endtask

  // directed sequence
  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] rd;
    int         snap_low;
    int         snap_rdy;

    rst                 = 1'b1;
    release_bus         = 1'b0;
    m_axis_data_tready  = 1'b1;
    m_scl               = 1'b1;
    m_sda               = 1'b1;
    src_en              = 1'b0;
    enable              = 1'b1;
    device_address      = 7'h50;
    device_address_mask = 7'h7F;
    wait_clks(5);

    // reset state
    chk("rst_lines", 32'({scl_o, scl_t, sda_o, sda_t}), 32'hF);
    chk("rst_flags", 32'({busy, bus_active, bus_addressed, m_axis_data_tvalid, s_axis_data_tready}), 32'h0);
    chk("rst_addr", 32'(bus_address), 32'h0);
    chk("rst_tdata", 32'(m_axis_data_tdata), 32'h0);
    rst = 1'b0;
    wait_clks(10);

    // write 0x12, 0x34 to 0x50
    i2c_start();
    chk("wr_bus_active", 32'(bus_active), 32'd1);
    send_byte(8'hA0, ack);
    chk("wr_addr_ack", 32'(ack), 32'd0);
    chk("wr_bus_address", 32'(bus_address), 32'h50);
    chk("wr_addressed", 32'(bus_addressed), 32'd1);
    send_byte(8'h12, ack);
    chk("wr_ack_12", 32'(ack), 32'd0);
    send_byte(8'h34, ack);
    chk("wr_ack_34", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    drain_expected();
    chk("wr_addressed_after_stop", 32'(bus_addressed), 32'd0);
    chk("wr_idle_after_stop", 32'({busy, bus_active}), 32'd0);

    // read 0xC3 (master ACK) then 0x5A (master NACK)
    src_en   = 1'b1;
    snap_rdy = tready_cnt;
    i2c_start();
    send_byte(8'hA1, ack);
    chk("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b0, rd);
    chk("rd_byte0", 32'(rd), 32'hC3);
    read_byte(1'b1, rd);
    chk("rd_byte1", 32'(rd), 32'h5A);
    wait_clks(10);
    chk("rd_idle_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    chk("rd_tready_pulses", 32'(tready_cnt - snap_rdy), 32'd2);
    chk("rd_bus_active_after_stop", 32'(bus_active), 32'd0);

    // wrong address 0x51: no ACK, SDA never pulled, no bytes out
    snap_low = sda_low_cnt;
    i2c_start();
    send_byte(8'hA2, ack);
    chk("nak_addr", 32'(ack), 32'd1);
    chk("nak_busy", 32'(busy), 32'd0);
    send_byte(8'h77, ack);
    chk("nak_data", 32'(ack), 32'd1);
    chk("nak_bus_active", 32'(bus_active), 32'd1);
    i2c_stop();
    chk("nak_sda_never_low", 32'(sda_low_cnt - snap_low), 32'd0);
    chk("nak_bus_active_after_stop", 32'(bus_active), 32'd0);
    drain_expected();

    // clock stretch while 0x12 is still unread
    m_axis_data_tready = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack);
    chk("st_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h12, ack);
    chk("st_ack_12", 32'(ack), 32'd0);
    wait_clks(10);
    chk("st_held_valid", 32'({m_axis_data_tvalid, m_axis_data_tdata}), 32'h112);
    send_bits8(8'h34);
    wait_clks(30);
    chk("st_scl_stretched", 32'(scl_t), 32'd0);
    wait_clks(60);
    chk("st_scl_still_stretched", 32'({w_scl_line, scl_t}), 32'd0);
    chk("st_tdata_kept", 32'(m_axis_data_tdata), 32'h12);
    m_axis_data_tready = 1'b1;
    wait_clks(2);
    chk("st_scl_released", 32'(scl_t), 32'd1);
    chk("st_tdata_34", 32'(m_axis_data_tdata), 32'h34);
    clock_bit(1'b1, ack);
    chk("st_ack_34", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    drain_expected();

    // 2-clk SDA glitch with SCL high is filtered out
    wait_clks(10);
    m_sda = 1'b0;
    wait_clks(2);
    m_sda = 1'b1;
    wait_clks(20);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_bus_active", 32'(bus_active), 32'd0);

    // release_bus during the address ACK drops the ACK at once
    i2c_start();
    send_byte(8'hA0, ack);
    chk("rel_addr_ack", 32'(ack), 32'd0);
    chk("rel_sda_driven", 32'(sda_t), 32'd0);
    release_bus = 1'b1;
    wait_clks(1);
    release_bus = 1'b0;
    chk("rel_sda_released", 32'({busy, sda_t}), 32'd1);
    chk("rel_bus_active", 32'(bus_active), 32'd1);
    i2c_stop();

    // enable low: matching address is not acknowledged
    enable = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack);
    chk("dis_no_ack", 32'(ack), 32'd1);
    chk("dis_not_addressed", 32'(bus_addressed), 32'd0);
    i2c_stop();
    enable = 1'b1;

    // reset in the middle of a read byte (0xC3, bit5 = 0 on the wire)
    i2c_start();
    send_byte(8'hA1, ack);
    chk("rr_addr_ack", 32'(ack), 32'd0);
    clock_bit(1'b1, dummy);
    clock_bit(1'b1, dummy);
    wait_clks(12);
    chk("rr_sda_driven", 32'(sda_t), 32'd0);
    rst = 1'b1;
    wait_clks(1);
    chk("rr_lines", 32'({scl_o, scl_t, sda_o, sda_t}), 32'hF);
    chk("rr_flags", 32'({busy, bus_active, bus_addressed, m_axis_data_tvalid, s_axis_data_tready}), 32'h0);
    chk("rr_addr", 32'(bus_address), 32'h0);
    chk("rr_tdata", 32'(m_axis_data_tdata), 32'h0);
    rst    = 1'b0;
    src_en = 1'b0;
    m_sda  = 1'b1;
    wait_clks(HALF);
    m_scl  = 1'b1;
    wait_clks(2 * HALF);
    chk("rr_idle_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
